// File: rtl/chacha_pkg.sv
// chacha_pkg: shared types and constants for the ChaCha keystream XOR block.
//   state_t   - stream sequencer states
//   BLK_BITS  - keystream block width (512)
//   WORD_W    - stream word width (32)
//   BLK_WORDS - words per keystream block (16)
//   CTR_W     - block counter width (64)
//   IDX_W     - word index width within a block
//   ks_word() - selects word idx from a block, word 0 = bits [511:480]
package chacha_pkg;

   localparam int unsigned BLK_BITS  = 512;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned BLK_WORDS = BLK_BITS / WORD_W;
   localparam int unsigned CTR_W     = 64;
   localparam int unsigned IDX_W     = $clog2(BLK_WORDS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_STREAM,
      ST_DONE
   } state_t;

   // Top bit of word idx is 511 - 32*idx, i.e. {~idx, 5'h1f} for 16 x 32-bit words.
   function automatic logic [WORD_W-1:0] ks_word(input logic [BLK_BITS-1:0] blk,
                                                 input logic [IDX_W-1:0]    idx);
      ks_word = blk[{~idx, 5'h1f} -: WORD_W];
   endfunction

endpackage

// File: rtl/chacha_ks_buf.sv
// chacha_ks_buf: keystream block buffer with word-select output.
// Build option: CHACHA_STREAM_XOR_PREFETCH_EN adds a spare block buffer that
// can be filled while the active one is being consumed, then swapped in.
// Ports:
//   clk, reset_n      - clock, async active-low reset
//   load_act          - capture blk_in into the active buffer
//   load_spare        - (prefetch) capture blk_in into the spare buffer
//   swap              - (prefetch) move spare into active, spare becomes empty
//   clr_spare         - (prefetch) discard spare contents
//   spare_full        - (prefetch) spare buffer holds an unused block
//   blk_in            - 512-bit keystream block from the core
//   word_idx          - word selector into the active buffer
//   ks_word_out       - selected 32-bit keystream word
module chacha_ks_buf
   import chacha_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                load_act,
`ifdef CHACHA_STREAM_XOR_PREFETCH_EN
   input  logic                load_spare,
   input  logic                swap,
   input  logic                clr_spare,
   output logic                spare_full,
`endif
   input  logic [BLK_BITS-1:0] blk_in,
   input  logic [IDX_W-1:0]    word_idx,
   output logic [WORD_W-1:0]   ks_word_out
);

   logic [BLK_BITS-1:0] act_q;

`ifdef CHACHA_STREAM_XOR_PREFETCH_EN
   logic [BLK_BITS-1:0] spare_q;
   logic                spare_full_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         act_q        <= '0;
         spare_q      <= '0;
         spare_full_q <= 1'b0;
      end else begin
         if (swap)
            act_q <= spare_q;
         else if (load_act)
            act_q <= blk_in;

         if (load_spare) begin
            spare_q      <= blk_in;
            spare_full_q <= 1'b1;
         end else if (swap || clr_spare) begin
            spare_full_q <= 1'b0;
         end
      end
   end

   assign spare_full = spare_full_q;
`else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         act_q <= '0;
      else if (load_act)
         act_q <= blk_in;
   end
`endif

   assign ks_word_out = ks_word(act_q, word_idx);

endmodule

// File: rtl/chacha_stream_xor.sv
// chacha_stream_xor: sequences chacha_core init/next requests, captures each
// 512-bit keystream block and XORs it into a 32-bit valid/ready word stream.
// Encryption and decryption are the same operation.
// Build option: CHACHA_STREAM_XOR_PREFETCH_EN requests block N+1 while block N
// streams and swaps it in at the block boundary without a bubble.
// Ports:
//   clk, reset_n                  - clock, async active-low reset
//   start, ctr_init               - begin a message (IDLE only), initial block counter
//   in_valid/in_ready/in_data/in_last    - plaintext stream in
//   out_valid/out_ready/out_data/out_last - ciphertext stream out
//   core_init, core_next, core_ctr        - request pulses and counter to chacha_core
//   core_ready, core_data_out, core_data_out_valid - chacha_core status / block
//   busy                          - high whenever not IDLE
//   ctr_wrap_err                  - sticky, block counter would have wrapped
// WORD_W and BLK_WORDS are fixed at 32 and 16; they are not meant to be overridden.
module chacha_stream_xor
   import chacha_pkg::*;
#(
   parameter int unsigned WORD_W    = 32,
   parameter int unsigned BLK_WORDS = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [CTR_W-1:0]    ctr_init,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WORD_W-1:0]   in_data,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WORD_W-1:0]   out_data,
   output logic                out_last,
   output logic                core_init,
   output logic                core_next,
   output logic [CTR_W-1:0]    core_ctr,
   input  logic                core_ready,
   input  logic [BLK_BITS-1:0] core_data_out,
   input  logic                core_data_out_valid,
   output logic                busy,
   output logic                ctr_wrap_err
);

   state_t             state_q;
   state_t             state_d;
   state_t             blk_next_state;
   logic [CTR_W-1:0]   blk_cnt_q;
   logic [IDX_W-1:0]   word_idx_q;
   logic               first_blk_q;
   logic               wrap_err_q;
   logic               xfer;
   logic               at_end;
   logic               ctr_max;
   logic               blk_end;
   logic               wrap;
   logic               load_act;
   logic [WORD_W-1:0]  ks_w;

   assign xfer    = (state_q == ST_STREAM) && in_valid && out_ready;
   assign at_end  = (word_idx_q == IDX_W'(BLK_WORDS - 1));
   assign ctr_max = &blk_cnt_q;
   assign blk_end = xfer && !in_last && at_end;
   assign wrap    = blk_end && ctr_max;

   assign ctr_wrap_err = wrap_err_q;

`ifdef CHACHA_STREAM_XOR_PREFETCH_EN
   logic pf_pend_q;
   logic pf_fire;
   logic pf_cap;
   logic spare_full;
   logic swap;
   logic load_spare;
   logic clr_spare;

   // Prefetch only when a further block exists and not on the cycle that ends
   // the block or message, so a request never races the boundary decision.
   assign pf_fire    = (state_q == ST_STREAM) && core_ready && !pf_pend_q && !spare_full &&
                       !ctr_max && !(xfer && (in_last || at_end));
   assign pf_cap     = (state_q == ST_STREAM) && pf_pend_q && core_data_out_valid;
   assign swap       = blk_end && !ctr_max && spare_full;
   // A prefetched block landing exactly on the boundary goes straight to active.
   assign load_act   = ((state_q == ST_WAIT) && core_data_out_valid) ||
                       (blk_end && !ctr_max && !spare_full && pf_cap);
   assign load_spare = pf_cap && !blk_end && !(xfer && in_last);
   assign clr_spare  = (state_q == ST_DONE);
   assign blk_next_state = (spare_full || pf_cap) ? ST_STREAM :
                           (pf_pend_q ? ST_WAIT : ST_REQ);
   // While streaming, the counter offered to the core is the one being prefetched.
   assign core_ctr   = (state_q == ST_STREAM) ? blk_cnt_q + CTR_W'(1) : blk_cnt_q;
`else
   assign load_act       = (state_q == ST_WAIT) && core_data_out_valid;
   assign blk_next_state = ST_REQ;
   assign core_ctr       = blk_cnt_q;
`endif

   chacha_ks_buf u_ks_buf (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_act    (load_act),
`ifdef CHACHA_STREAM_XOR_PREFETCH_EN
      .load_spare  (load_spare),
      .swap        (swap),
      .clr_spare   (clr_spare),
      .spare_full  (spare_full),
`endif
      .blk_in      (core_data_out),
      .word_idx    (word_idx_q),
      .ks_word_out (ks_w)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_REQ;
         ST_REQ:    if (core_ready) state_d = ST_WAIT;
         ST_WAIT:   if (core_data_out_valid) state_d = ST_STREAM;
         ST_STREAM: begin
            if (xfer) begin
               if (in_last || wrap)
                  state_d = ST_DONE;
               else if (at_end)
                  state_d = blk_next_state;
            end
         end
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      core_init = 1'b0;
      core_next = 1'b0;
      busy      = (state_q != ST_IDLE);
      case (state_q)
         ST_REQ: begin
            core_init = core_ready && first_blk_q;
            core_next = core_ready && !first_blk_q;
         end
         ST_STREAM: begin
            in_ready  = out_ready;
            out_valid = in_valid;
            out_data  = in_data ^ ks_w;
            out_last  = in_last;
`ifdef CHACHA_STREAM_XOR_PREFETCH_EN
            core_next = pf_fire;
`endif
         end
         default: ;
      endcase
   end

   // Counter, word index and flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blk_cnt_q   <= '0;
         word_idx_q  <= '0;
         first_blk_q <= 1'b0;
         wrap_err_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  blk_cnt_q   <= ctr_init;
                  first_blk_q <= 1'b1;
                  wrap_err_q  <= 1'b0;
               end
            end
            ST_REQ: begin
               if (core_ready)
                  first_blk_q <= 1'b0;
            end
            ST_WAIT: begin
               if (core_data_out_valid)
                  word_idx_q <= '0;
            end
            ST_STREAM: begin
               if (xfer && !in_last) begin
                  if (!at_end) begin
                     word_idx_q <= word_idx_q + IDX_W'(1);
                  end else if (ctr_max) begin
                     wrap_err_q <= 1'b1;
                  end else begin
                     blk_cnt_q  <= blk_cnt_q + CTR_W'(1);
                     word_idx_q <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CHACHA_STREAM_XOR_PREFETCH_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         pf_pend_q <= 1'b0;
      else if (state_q == ST_DONE)
         pf_pend_q <= 1'b0;
      else if (pf_fire)
         pf_pend_q <= 1'b1;
      else if (core_data_out_valid && (state_q == ST_STREAM || state_q == ST_WAIT))
         pf_pend_q <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_chacha_stream_xor.sv
// Testbench for chacha_stream_xor with a behavioural chacha_core stand-in.
// Block for counter 0 is the all-zero key/nonce ChaCha20 reference block;
// other counters use a fixed synthetic pattern.
`timescale 1ns/1ps
module tb_chacha_stream_xor;

   localparam int LAT = 4;
   localparam logic [511:0] ZERO_BLK =
      512'h76b8e0ad_a0f13d90_405d6ae5_5386bd28_bdd219b8_a08ded1a_a836efcc_8b770dc7_da41597c_5157488d_7724e03f_b8d84a37_6a43b8f4_1518a11c_c387b669_b2ee6586;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [63:0]   ctr_init = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_data = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [31:0]   out_data;
   logic          out_last;
   logic          core_init;
   logic          core_next;
   logic [63:0]   core_ctr;
   logic          m_ready = 1'b1;
   logic [511:0]  m_data = '0;
   logic          m_valid = 1'b0;
   logic          busy;
   logic          ctr_wrap_err;

   int            n_pass = 0;
   int            n_chk = 0;
   int            n_init = 0;
   int            n_next = 0;
   logic [32:0]   sb_q[$];

   always #5 clk = ~clk;

   chacha_stream_xor dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .start               (start),
      .ctr_init            (ctr_init),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_data             (in_data),
      .in_last             (in_last),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_data            (out_data),
      .out_last            (out_last),
      .core_init           (core_init),
      .core_next           (core_next),
      .core_ctr            (core_ctr),
      .core_ready          (m_ready),
      .core_data_out       (m_data),
      .core_data_out_valid (m_valid),
      .busy                (busy),
      .ctr_wrap_err        (ctr_wrap_err)
   );

   function automatic logic [511:0] ref_blk(input logic [63:0] c);
      logic [511:0] b;
      if (c == 64'd0) begin
         b = ZERO_BLK;
      end else begin
         for (int i = 0; i < 16; i++)
            b[511-32*i -: 32] = (c[31:0] * 32'h9e3779b9) ^ (32'(i) * 32'h01000193) ^ c[63:32];
      end
      return b;
   endfunction

   function automatic logic [127:0] outs_all();
      return {25'd0, core_ctr, out_data, in_ready, out_valid, out_last,
              core_init, core_next, busy, ctr_wrap_err};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   // Core stand-in: request seen mid-cycle, ready drops just after the edge,
   // block returned LAT cycles later and held valid until the next request.
   initial begin : core_model
      logic        fired;
      logic [63:0] req_ctr;
      int          lat;
      req_ctr = '0;
      lat = 0;
      forever begin
         @(negedge clk);
         fired = core_init || core_next;
         if (fired) begin
            check("pulse_excl", 128'(core_init & core_next), 128'd0);
            if (core_init) n_init++;
            if (core_next) n_next++;
            req_ctr = core_ctr;
         end
         @(posedge clk);
         #1;
         if (fired) begin
            m_ready = 1'b0;
            m_valid = 1'b0;
            lat = LAT;
         end else if (!m_ready) begin
            if (lat == 0) begin
               m_ready = 1'b1;
               m_valid = 1'b1;
               m_data  = ref_blk(req_ctr);
            end else begin
               lat--;
            end
         end
      end
   end

   // Scoreboard monitor
   always @(negedge clk) begin
      logic [32:0] e;
      if (reset_n && out_valid && out_ready) begin
         check("sb_has_entry", 128'(sb_q.size() != 0), 128'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("out_word", 128'({out_last, out_data}), 128'(e));
         end
      end
   end

   task automatic do_start(input logic [63:0] c);
      ctr_init = c;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send_words(input logic [63:0] c0, input int n, input bit last_on_end,
                             input bit rnd, input logic [31:0] pt_mul);
      logic [511:0] b;
      logic [31:0]  pt;
      bit           acc;
      for (int w = 0; w < n; w++) begin
         b  = ref_blk(c0 + 64'(w / 16));
         pt = 32'(w + 1) * pt_mul;
         in_data  = pt;
         in_last  = last_on_end && (w == n - 1);
         in_valid = 1'b1;
         sb_q.push_back({in_last, pt ^ b[511-32*(w%16) -: 32]});
         acc = 1'b0;
         for (int to = 0; to < 300 && !acc; to++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
         end
         if (!acc) begin
            n_chk++;
            $display("FAIL word_accept_timeout: word %0d not accepted, required within 300 cycles", w);
         end
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int i0;
      int n0;
      int acc_cnt;
      int to;

      // Reset with stream inputs active: every output must stay low.
      in_valid = 1'b1;
      in_data  = 32'hdeadbeef;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", outs_all(), 128'd0);
      in_valid = 1'b0;
      reset_n  = 1'b1;
      @(posedge clk);
      #1;

      // 1: reference block, 16 zero words
      i0 = n_init; n0 = n_next;
      do_start(64'd0);
      send_words(64'd0, 16, 1'b1, 1'b0, 32'd0);
      check("t1_busy_done", 128'(busy), 128'd1);
      @(posedge clk);
      #1;
      check("t1_busy_idle", 128'(busy), 128'd0);
      check("t1_init_cnt", 128'(n_init - i0), 128'd1);
      check("t1_next_cnt", 128'(n_next - n0), 128'd0);

      // 2: 40-word message across three blocks
      i0 = n_init; n0 = n_next;
      do_start(64'd5);
      send_words(64'd5, 40, 1'b1, 1'b0, 32'h01010101);
      @(posedge clk);
      #1;
      check("t2_init_cnt", 128'(n_init - i0), 128'd1);
      check("t2_next_cnt", 128'(n_next - n0), 128'd2);
      check("t2_blk_cnt", 128'(core_ctr), 128'd7);

      // 3: random back-pressure
      do_start(64'd9);
      send_words(64'd9, 24, 1'b1, 1'b1, 32'h13579bdf);
      repeat (2) @(posedge clk);
      #1;
      check("t3_idle", 128'(busy), 128'd0);

      // 4: counter wrap after block FFFF_FFFF_FFFF_FFFF
      n0 = n_next;
      do_start(64'hffff_ffff_ffff_ffff);
      send_words(64'hffff_ffff_ffff_ffff, 16, 1'b0, 1'b0, 32'h0badf00d);
      check("t4_wrap_err", 128'(ctr_wrap_err), 128'd1);
      check("t4_busy_done", 128'(busy), 128'd1);
      in_valid = 1'b1;
      in_data  = 32'h17171717;
      acc_cnt  = 0;
      repeat (4) begin
         @(negedge clk);
         if (in_ready) acc_cnt++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("t4_no_accept", 128'(acc_cnt), 128'd0);
      check("t4_idle", 128'(busy), 128'd0);
      check("t4_wrap_sticky", 128'(ctr_wrap_err), 128'd1);
      check("t4_next_cnt", 128'(n_next - n0), 128'd0);

      // 5: reset in WAIT, then mid-STREAM
      i0 = n_init;
      do_start(64'd3);
      check("t5_wrap_clr", 128'(ctr_wrap_err), 128'd0);
      to = 0;
      while (n_init == i0 && to < 50) begin
         @(posedge clk);
         #1;
         to++;
      end
      check("t5_init_seen", 128'(n_init - i0), 128'd1);
      reset_n  = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'h5a5a5a5a;
      #1;
      check("t5_rst_wait_outs", outs_all(), 128'd0);
      @(posedge clk);
      #1;
      reset_n  = 1'b1;
      in_valid = 1'b0;

      i0 = n_init; n0 = n_next;
      do_start(64'd3);
      send_words(64'd3, 5, 1'b0, 1'b0, 32'h00ff00ff);
      check("t5_restart_init", 128'(n_init - i0), 128'd1);
      check("t5_restart_next", 128'(n_next - n0), 128'd0);
      reset_n  = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'ha5a5a5a5;
      #1;
      check("t5_rst_stream_outs", outs_all(), 128'd0);
      @(posedge clk);
      #1;
      reset_n  = 1'b1;
      in_valid = 1'b0;

      i0 = n_init; n0 = n_next;
      do_start(64'd0);
      send_words(64'd0, 3, 1'b1, 1'b0, 32'h11111111);
      @(posedge clk);
      #1;
      check("t5_again_init", 128'(n_init - i0), 128'd1);
      check("t5_again_next", 128'(n_next - n0), 128'd0);

      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", 128'(sb_q.size()), 128'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
